// File: rtl/writeback_queue.sv
// Writeback queue: ALU/load results -> one register-file write per cycle, head presented one edge after push; InReady drops when fewer than two slots remain.
// Define WB_BYPASS_EN to enable the youngest-match read bypass over queued entries.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     AluValid,
  input  logic [4:0]               AluReg,
  input  logic [31:0]              AluData,
  input  logic                     LdValid,
  input  logic [4:0]               LdReg,
  input  logic [31:0]              LdData,
  output logic                     InReady,
  output logic [4:0]               WriteReg,
  output logic [1:0]               RegWrite,
  output logic [31:0]              WriteData,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  input  logic [4:0]               Read1,
  input  logic [4:0]               Read2,
  output logic                     Fwd1Hit,
  output logic                     Fwd2Hit,
  output logic [31:0]              Fwd1Data,
  output logic [31:0]              Fwd2Data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  rg;
    logic [31:0] dat;
  } wb_entry_t;

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              in_ready;
  logic              alu_ok, ld_ok, pop_en;
  logic [1:0]        n_push;
  logic [PW-1:0]     ld_slot;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    n_push     = 2'd0;
    // Writes to r0 are architecturally void, so they never occupy a slot.
    alu_ok     = AluValid && (AluReg != 5'd0);
    ld_ok      = LdValid && (LdReg != 5'd0);
    in_ready   = (count_q <= CW'(DEPTH - 2));
    pop_en     = (count_q != '0);
    ld_slot    = wr_ptr_q + PW'(alu_ok);
    if (in_ready) begin
      if (alu_ok) mem_d[wr_ptr_q] = '{rg: AluReg, dat: AluData};
      if (ld_ok)  mem_d[ld_slot]  = '{rg: LdReg, dat: LdData};
      n_push   = {1'b0, alu_ok} + {1'b0, ld_ok};
      wr_ptr_d = wr_ptr_q + PW'(n_push);
    end else if (alu_ok || ld_ok) begin
      overflow_d = 1'b1;
    end
    rd_ptr_d = rd_ptr_q + PW'(pop_en);
    count_d  = count_q + CW'(n_push) - CW'(pop_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign InReady   = in_ready;
  assign Count     = count_q;
  assign Overflow  = overflow_q;
  assign RegWrite  = {1'b0, pop_en};
  assign WriteReg  = pop_en ? mem_q[rd_ptr_q].rg  : 5'd0;
  assign WriteData = pop_en ? mem_q[rd_ptr_q].dat : 32'd0;

`ifdef WB_BYPASS_EN
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    Fwd1Hit  = 1'b0;
    Fwd1Data = 32'd0;
    Fwd2Hit  = 1'b0;
    Fwd2Data = 32'd0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (Read1 != 5'd0 && mem_q[idx].rg == Read1) begin
          Fwd1Hit  = 1'b1;
          Fwd1Data = mem_q[idx].dat;
        end
        if (Read2 != 5'd0 && mem_q[idx].rg == Read2) begin
          Fwd2Hit  = 1'b1;
          Fwd2Data = mem_q[idx].dat;
        end
      end
    end
  end
`else
  logic unused_read;
  assign unused_read = ^{Read1, Read2};
  assign Fwd1Hit  = 1'b0;
  assign Fwd2Hit  = 1'b0;
  assign Fwd1Data = 32'd0;
  assign Fwd2Data = 32'd0;
`endif

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, minimum 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port AluValid  input  1  ALU result present this cycle.
REQ-005 SHALL have port AluReg  input  5  ALU destination register.
REQ-006 SHALL have port AluData  input  32  ALU result value.
REQ-007 SHALL have port LdValid  input  1  load result present this cycle.
REQ-008 SHALL have port LdReg  input  5  load destination register.
REQ-009 SHALL have port LdData  input  32  load result value.
REQ-010 SHALL have port InReady  output  1  queue accepts pushes this cycle.
REQ-011 SHALL have port WriteReg  output  5  register-file write address.
REQ-012 SHALL have port RegWrite  output  2  register-file write enable (2'b01 = write, 2'b00 = idle).
REQ-013 SHALL have port WriteData  output  32  register-file write data.
REQ-014 SHALL have port Count  output  $clog2(DEPTH)+1  occupied entries.
REQ-015 SHALL have port Overflow  output  1  sticky flag: a valid result was dropped.
REQ-016 SHALL have ports Read1, Read2  input  5 each  register-file read addresses, for bypass.
REQ-017 SHALL have ports Fwd1Hit, Fwd2Hit  output  1 each, and Fwd1Data, Fwd2Data  output  32 each  bypass results.

Function
REQ-018 InReady SHALL be 1 iff DEPTH-Count >= 2, computed from registered Count only.
REQ-019 On a rising edge with InReady=1, each asserted valid SHALL push one entry {Reg,Data}; when both push, ALU entry SHALL be older than load entry.
REQ-020 A valid result with Reg==0 SHALL be discarded, not queued, with no Overflow.
REQ-021 A valid result (Reg!=0) while InReady=0 SHALL be dropped and SHALL set Overflow to 1 at that edge.
REQ-022 While Count!=0, outputs SHALL combinationally present the head entry: WriteReg=head.Reg, WriteData=head.Data, RegWrite=2'b01.
REQ-023 While Count==0, outputs SHALL be WriteReg=0, WriteData=0, RegWrite=2'b00.
REQ-024 Each rising edge with Count!=0 SHALL pop the head; one write drains per cycle.
REQ-025 Push and pop in the same edge SHALL both occur; Count(next)=Count+pushes-pop.
REQ-026 Latency: a result pushed into an empty queue at edge N SHALL appear on the outputs after edge N and be written by the register file at edge N+1.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; Count SHALL span 0..DEPTH and never exceed DEPTH.
REQ-028 Entries SHALL drain in strict push order.

Reset
REQ-029 rst_n=0 SHALL immediately clear pointers, Count=0, and Overflow=0; outputs therefore read WriteReg=0, WriteData=0, RegWrite=2'b00, InReady=1.
REQ-030 Reset mid-operation SHALL discard all queued entries without issuing their writes.
REQ-031 Overflow SHALL clear only on reset.

Configuration
REQ-032 With WB_BYPASS_EN defined, FwdkHit SHALL be 1 iff Readk!=0 and some queued entry has Reg==Readk, and FwdkData SHALL be the youngest matching entry's Data (0 when no hit).
REQ-033 Without WB_BYPASS_EN, Fwd1Hit=Fwd2Hit=0 and Fwd1Data=Fwd2Data=0 constantly, with no compare logic present.

Verification
REQ-034 Single push: AluValid=1, AluReg=1, AluData=32'h55555555 into an empty queue -> next cycle WriteReg=1, WriteData=32'h55555555, RegWrite=2'b01; one cycle later RegWrite=2'b00, Count=0.
REQ-035 Dual push: ALU {2,32'hAAAAAAAA} and Ld {3,32'h00000000} on the same edge -> writes to reg 2, then reg 3, on consecutive cycles.
REQ-036 Fill: DEPTH=4, two dual pushes with no pop window -> InReady=0 at Count>=3; a further AluValid with Reg=5 -> Overflow=1, Count unchanged by that result.
REQ-037 Reg 0: LdValid=1, LdReg=0 -> Count stays 0, RegWrite stays 2'b00, Overflow=0.
REQ-038 Bypass (WB_BYPASS_EN): queued {1,32'h55555555}, then {1,32'hAAAAAAAA}, with Read2=1 -> Fwd2Hit=1, Fwd2Data=32'hAAAAAAAA; Read1=0 -> Fwd1Hit=0.
REQ-039 Reset with Count=3: assert rst_n=0 -> Count=0, RegWrite=2'b00 immediately; no pending write is issued after release.
